// File: rtl/cpu_sequencer.sv
`default_nettype none
// =============================================================================
// Module  : cpu_sequencer
// Purpose : Multi-cycle fetch/decode/execute control sequencer that shares one
//           single-port memory between instruction fetch and data access.
// Option  : CPU_SEQ_INSTR_COUNT_EN adds the instr_count retired-instruction port.
// Rev     : 1.0
// =============================================================================
module cpu_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 10
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       ir,
    input  logic              dec_load,
    input  logic              dec_store,
    input  logic              dec_branch,
    input  logic              dec_halt,
    input  logic [ADDR_W-1:0] dec_addr,
    output logic              rf_we,
    output logic [31:0]       pc,
    output logic              halted
`ifdef CPU_SEQ_INSTR_COUNT_EN
    ,
    output logic [31:0]       instr_count
`endif
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM_RD = 3'd3,
        S_WB     = 3'd4,
        S_MEM_WR = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic        run_q;
    logic [31:0] pc_inc;
    logic [31:0] branch_pc;

    assign pc_inc    = pc_q + 32'd4;
    assign branch_pc = {{(32-ADDR_W-2){1'b0}}, dec_addr, 2'b00};

    // run_q holds off the first fetch until one edge has seen reset_n high.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            run_q   <= 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        mem_addr = pc_q[ADDR_W+1:2];
        rf_we    = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (run_q) begin
                    mem_rd = 1'b1;
                    if (mem_ready) begin
                        ir_d    = mem_rdata;
                        state_d = S_DECODE;
                    end
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                if (dec_halt) begin
                    state_d = S_HALT;
                end else if (dec_branch) begin
                    pc_d    = branch_pc;
                    state_d = S_FETCH;
                end else if (dec_load) begin
                    state_d = S_MEM_RD;
                end else if (dec_store) begin
                    state_d = S_MEM_WR;
                end else begin
                    rf_we   = 1'b1;
                    pc_d    = pc_inc;
                    state_d = S_FETCH;
                end
            end
            S_MEM_RD: begin
                mem_rd   = 1'b1;
                mem_addr = dec_addr;
                if (mem_ready) state_d = S_WB;
            end
            S_WB: begin
                rf_we   = 1'b1;
                pc_d    = pc_inc;
                state_d = S_FETCH;
            end
            S_MEM_WR: begin
                mem_wr   = 1'b1;
                mem_addr = dec_addr;
                if (mem_ready) begin
                    pc_d    = pc_inc;
                    state_d = S_FETCH;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    assign ir     = ir_q;
    assign pc     = pc_q;
    assign halted = (state_q == S_HALT);

`ifdef CPU_SEQ_INSTR_COUNT_EN
    // Only EXEC, WB and MEM_WR can enter FETCH from another state.
    logic        retire;
    logic [31:0] count_q;

    assign retire = (state_q != S_FETCH) && (state_d == S_FETCH);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (retire) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign instr_count = count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`default_nettype none
// =============================================================================
// Module  : tb_cpu_sequencer
// Purpose : Randomized scoreboard bench for cpu_sequencer; the bench plays both
//           the memory and the instruction decoder.
// Rev     : 1.0
// =============================================================================
module tb_cpu_sequencer;

    localparam int          ADDR_W      = 10;
    localparam logic [31:0] RESET_PC_TB = 32'hFFFF_FFF0;
    localparam int          EV_RD       = 0;
    localparam int          EV_WR       = 1;
    localparam int          EV_RFWE     = 2;
    localparam logic [31:0] OP_HALT     = 32'h8000_0000;
    localparam logic [31:0] OP_BRANCH   = 32'h4000_0000;
    localparam logic [31:0] OP_LOAD     = 32'h2000_0000;
    localparam logic [31:0] OP_STORE    = 32'h1000_0000;

    typedef struct {
        int              kind;
        logic [ADDR_W-1:0] addr;
        logic [31:0]     pc;
        int              lat;
        int              gap;
        bit              is_fetch;
    } ev_t;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd, mem_wr;
    logic              mem_ready = 1'b0;
    logic [31:0]       mem_rdata = '0;
    logic [31:0]       ir;
    logic              dec_load, dec_store, dec_branch, dec_halt;
    logic [ADDR_W-1:0] dec_addr;
    logic              rf_we;
    logic [31:0]       pc;
    logic              halted;
`ifdef CPU_SEQ_INSTR_COUNT_EN
    logic [31:0]       instr_count;
`endif

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          dly_mode = 0;
    int          dly_fixed = 0;
    int          last_evt_cyc = 0;
    int          last_fetch_cyc = 0;
    logic [31:0] prog [0:(1<<ADDR_W)-1];
    ev_t         exp_q[$];

    bit          rsp_pending = 1'b0;
    int          rsp_wait = 0;
    int          hold = 0;
    logic [ADDR_W-1:0] hold_addr = '0;
    logic        hold_rd = 1'b0;

    cpu_sequencer #(
        .RESET_PC (RESET_PC_TB),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .ir         (ir),
        .dec_load   (dec_load),
        .dec_store  (dec_store),
        .dec_branch (dec_branch),
        .dec_halt   (dec_halt),
        .dec_addr   (dec_addr),
        .rf_we      (rf_we),
        .pc         (pc),
        .halted     (halted)
`ifdef CPU_SEQ_INSTR_COUNT_EN
        ,
        .instr_count(instr_count)
`endif
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Instruction encoding owned by this bench: flag bits 31..28, address in the low bits.
    assign dec_halt   = ir[31];
    assign dec_branch = ir[30];
    assign dec_load   = ir[29];
    assign dec_store  = ir[28];
    assign dec_addr   = ir[ADDR_W-1:0];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic ev_t mk(int k, logic [ADDR_W-1:0] a, logic [31:0] p, int lat, int gap, bit f);
        ev_t e;
        e.kind = k; e.addr = a; e.pc = p; e.lat = lat; e.gap = gap; e.is_fetch = f;
        return e;
    endfunction

    // Reference model: walks the program instruction by instruction.
    task automatic build_expect(input int limit, output bit halt_end, output int nonhalt,
                                output logic [31:0] final_pc);
        logic [31:0] p;
        logic [31:0] w;
        int          lat;
        p = RESET_PC_TB; lat = 1; nonhalt = 0; halt_end = 1'b0;
        for (int n = 0; n < limit && !halt_end; n++) begin
            w = prog[p[ADDR_W+1:2]];
            exp_q.push_back(mk(EV_RD, p[ADDR_W+1:2], p, lat, -1, 1'b1));
            if (w[31]) begin
                halt_end = 1'b1;
            end else begin
                nonhalt++;
                if (w[30]) begin
                    p = {{(32-ADDR_W-2){1'b0}}, w[ADDR_W-1:0], 2'b00};
                    lat = 3;
                end else if (w[29]) begin
                    exp_q.push_back(mk(EV_RD, w[ADDR_W-1:0], p, -1, -1, 1'b0));
                    exp_q.push_back(mk(EV_RFWE, '0, p, -1, 1, 1'b0));
                    p = p + 32'd4; lat = 5;
                end else if (w[28]) begin
                    exp_q.push_back(mk(EV_WR, w[ADDR_W-1:0], p, -1, -1, 1'b0));
                    p = p + 32'd4; lat = 4;
                end else begin
                    exp_q.push_back(mk(EV_RFWE, '0, p, -1, 2, 1'b0));
                    p = p + 32'd4; lat = 3;
                end
            end
        end
        if (!halt_end) exp_q.push_back(mk(EV_RD, p[ADDR_W+1:2], p, lat, -1, 1'b1));
        final_pc = p;
    endtask

    // Memory responder: per-request latency drawn when the request first appears.
    initial begin
        forever begin
            @(negedge clock);
            if (mem_rd || mem_wr) begin
                if (!rsp_pending) begin
                    rsp_pending = 1'b1;
                    rsp_wait = (dly_mode == 0) ? 0 : (dly_mode == 1) ? dly_fixed : int'($urandom_range(0, 3));
                end
                if (rsp_wait == 0) begin
                    mem_ready   = 1'b1;
                    mem_rdata   = mem_rd ? prog[mem_addr] : $urandom();
                    rsp_pending = 1'b0;
                end else begin
                    mem_ready = 1'b0;
                    mem_rdata = $urandom();
                    rsp_wait--;
                end
            end else begin
                rsp_pending = 1'b0;
                mem_ready   = ($urandom_range(0, 1) == 1);
                mem_rdata   = $urandom();
            end
        end
    end

    task automatic compare_event(input int k, input logic [ADDR_W-1:0] a);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_event got_kind=%0d addr=%0h pc=%0h required=none", k, a, pc);
        end else begin
            e = exp_q.pop_front();
            check("ev_kind", k, e.kind);
            if (e.kind != EV_RFWE) check("ev_addr", 32'(a), 32'(e.addr));
            check("ev_pc", pc, e.pc);
            if (e.gap >= 0) check("ev_gap", cyc - last_evt_cyc, e.gap);
            if (e.is_fetch && dly_mode == 0 && e.lat > 0) check("instr_latency", cyc - last_fetch_cyc, e.lat);
            if (e.is_fetch) last_fetch_cyc = cyc;
        end
        last_evt_cyc = cyc;
    endtask

    // Monitor: samples mid-cycle, after the responder has settled mem_ready.
    initial begin
        forever begin
            @(negedge clock);
            #2;
            if (!reset_n) begin
                hold = 0;
            end else begin
                if (mem_rd || mem_wr) begin
                    check("rd_wr_exclusive", 32'(mem_rd & mem_wr), 32'd0);
                    if (hold > 0) check("req_stable", {mem_rd, 21'd0, mem_addr}, {hold_rd, 21'd0, hold_addr});
                    hold++;
                    hold_addr = mem_addr;
                    hold_rd   = mem_rd;
                    if (mem_ready) begin
                        if (dly_mode == 1) check("req_hold_cycles", hold, dly_fixed + 1);
                        compare_event(mem_rd ? EV_RD : EV_WR, mem_addr);
                        hold = 0;
                    end
                end else begin
                    hold = 0;
                end
                if (rf_we) compare_event(EV_RFWE, '0);
            end
        end
    end

    task automatic assert_reset();
        @(negedge clock);
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        check("rst_pc", pc, RESET_PC_TB);
        check("rst_ir", ir, 32'd0);
        check("rst_ctrl", {28'd0, rf_we, halted, mem_rd, mem_wr}, 32'd0);
    endtask

    task automatic release_reset();
        @(negedge clock);
        reset_n        = 1'b1;
        last_evt_cyc   = cyc;
        last_fetch_cyc = cyc;
    endtask

    task automatic fill_random();
        logic [31:0] w;
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            w = $urandom() & 32'h0FFF_FFFF;
            if ($urandom_range(0, 99) < 4)  w = w | OP_HALT;
            if ($urandom_range(0, 99) < 20) w = w | OP_BRANCH;
            if ($urandom_range(0, 99) < 30) w = w | OP_LOAD;
            if ($urandom_range(0, 99) < 30) w = w | OP_STORE;
            prog[i] = w;
        end
    endtask

    task automatic run_prog(input int limit);
        bit          halt_end;
        bit          done;
        int          nonhalt;
        int          quiet;
        logic [31:0] final_pc;
        assert_reset();
        exp_q.delete();
        build_expect(limit, halt_end, nonhalt, final_pc);
        release_reset();
        done = 1'b0;
        for (int i = 0; i < 6000 && !done; i++) begin
            @(negedge clock);
            done = (exp_q.size() == 0);
        end
        check("scoreboard_drained", 32'(done), 32'd1);
        if (halt_end && done) begin
            repeat (3) @(negedge clock);
            #1;
            check("halted", 32'(halted), 32'd1);
            check("halt_pc", pc, final_pc);
`ifdef CPU_SEQ_INSTR_COUNT_EN
            check("instr_count", instr_count, nonhalt);
`endif
            quiet = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clock);
                #1;
                if (mem_rd || mem_wr || rf_we || !halted) quiet++;
            end
            check("halt_quiet", quiet, 0);
`ifdef CPU_SEQ_INSTR_COUNT_EN
            check("instr_count_hold", instr_count, nonhalt);
`endif
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;

        // ALU ops across the top of the address space: latency and pc wrap to 0.
        fill_random();
        for (int i = 'h3FC; i <= 'h3FF; i++) prog[i] = 32'h0000_0123;
        prog[0] = OP_HALT;
        dly_mode = 0;
        run_prog(20);

        // Load from 0x3F with two wait states on every request.
        fill_random();
        prog['h3FC] = OP_LOAD | 32'h0000_003F;
        prog['h3FD] = OP_HALT;
        dly_mode = 1; dly_fixed = 2;
        run_prog(20);

        // Branch outranks load.
        fill_random();
        prog['h3FC] = OP_BRANCH | OP_LOAD | 32'h0000_0010;
        prog['h010] = OP_HALT;
        dly_mode = 0;
        run_prog(20);

        // Reset while a store is stalled on mem_ready.
        fill_random();
        prog['h3FC] = OP_STORE | 32'h0000_0055;
        dly_mode = 1; dly_fixed = 5;
        assert_reset();
        exp_q.delete();
        exp_q.push_back(mk(EV_RD, RESET_PC_TB[ADDR_W+1:2], RESET_PC_TB, 1, -1, 1'b1));
        release_reset();
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clock);
            #1;
            found = mem_wr;
        end
        check("store_wait_seen", 32'(found), 32'd1);
        @(negedge clock);
        #1;
        reset_n = 1'b0;
        @(negedge clock);
        #1;
        check("abort_ctrl", {29'd0, mem_wr, mem_rd, rf_we}, 32'd0);
        check("abort_pc", pc, RESET_PC_TB);
        check("abort_queue", exp_q.size(), 0);

        // Random programs under all memory-latency modes.
        for (int r = 0; r < 24; r++) begin
            fill_random();
            dly_mode  = int'($urandom_range(0, 2));
            dly_fixed = int'($urandom_range(1, 3));
            run_prog(40);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
